// File: rtl/serial_alu_pkg.sv
// Shared ALU encodings and status words for the controller/execution boundary.
package defs;

  typedef enum logic [3:0] {
    ADD = 4'd1,
    SUB = 4'd2,
    AND = 4'd3,
    OR  = 4'd4,
    XOR = 4'd5
  } t_aluop;

  typedef struct packed {
    logic sign;
    logic zero;
    logic overflow;
    logic carryOut;
  } t_flag;

  typedef struct packed {
    logic ge;
    logic lt;
    logic ne;
    logic eq;
  } t_cmp;

  function automatic logic is_arith(t_aluop op);
    return (op == ADD) || (op == SUB);
  endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// One SLICE-bit step of the serial datapath: main ALU slice plus the always-on a-b compare slice.
module alu_slice
  import defs::*;
#(
  parameter int SLICE = 8
) (
  input  t_aluop           op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  logic             ccin,
  output logic [SLICE-1:0] r,
  output logic             cout,
  output logic [SLICE-1:0] d,
  output logic             ccout,
  output logic             cmsb
);

  logic [SLICE-1:0] bx;
  logic [SLICE:0]   sum;
  logic [SLICE-1:0] lo;
  logic [SLICE:0]   dsum;

  always_comb begin
    bx   = (op == SUB) ? ~b : b;
    sum  = {1'b0, a} + {1'b0, bx} + {{SLICE{1'b0}}, cin};
    // low SLICE-1 bits only: bit SLICE-1 of this is the carry into the slice MSB
    lo   = {1'b0, a[SLICE-2:0]} + {1'b0, bx[SLICE-2:0]} + {{(SLICE-1){1'b0}}, cin};
    dsum = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, ccin};
    d     = dsum[SLICE-1:0];
    ccout = dsum[SLICE];
    r    = '0;
    cout = 1'b0;
    cmsb = 1'b0;
    case (op)
      ADD, SUB: begin
        r    = sum[SLICE-1:0];
        cout = sum[SLICE];
        cmsb = lo[SLICE-1];
      end
      AND:     r = a & b;
      OR:      r = a | b;
      XOR:     r = a ^ b;
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Slice-serial ALU: LSB-first over N = WIDTH/SLICE cycles (N >= 2), valid/ready on both sides.
module serial_alu
  import defs::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output t_flag            flag,
  output t_cmp             cmp
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} t_state;

  t_state                 state;
  logic [CW-1:0]          cnt;
  t_aluop                 op_q;
  logic [WIDTH-1:0]       a_sh, b_sh;
  logic [WIDTH-SLICE-1:0] res_sh;
  logic                   carry, ccarry, zacc, dzacc;

  logic [SLICE-1:0] r_s, d_s;
  logic             cout, ccout, cmsb;
  logic [WIDTH-1:0] res_next;
  logic             last, arith, dsign, dov, lt, deq;

  alu_slice #(.SLICE(SLICE)) u_slice (
    .op(op_q), .a(a_sh[SLICE-1:0]), .b(b_sh[SLICE-1:0]),
    .cin(carry), .ccin(ccarry),
    .r(r_s), .cout(cout), .d(d_s), .ccout(ccout), .cmsb(cmsb)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign res_next  = {r_s, res_sh};
  assign last      = (cnt == CW'(N - 1));
  assign arith     = is_arith(op_q);

  // Compare flags are only meaningful on the MSB slice, where a_sh/b_sh hold the operand tops.
  assign dsign = d_s[SLICE-1];
  assign dov   = (a_sh[SLICE-1] ^ b_sh[SLICE-1]) & (dsign ^ a_sh[SLICE-1]);
  assign lt    = dsign ^ dov;
  assign deq   = dzacc & ~|d_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= ADD;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      ccarry <= 1'b1;
      zacc   <= 1'b1;
      dzacc  <= 1'b1;
      result <= '0;
      flag   <= '0;
      cmp    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q   <= t_aluop'(op);
          a_sh   <= a;
          b_sh   <= b;
          cnt    <= '0;
          carry  <= (op == SUB);
          ccarry <= 1'b1;
          zacc   <= 1'b1;
          dzacc  <= 1'b1;
          state  <= RUN;
        end
        RUN: begin
          a_sh   <= a_sh >> SLICE;
          b_sh   <= b_sh >> SLICE;
          res_sh <= res_next[WIDTH-1:SLICE];
          carry  <= cout;
          ccarry <= ccout;
          zacc   <= zacc & ~|r_s;
          dzacc  <= deq;
          cnt    <= cnt + 1'b1;
          if (last) begin
            result <= res_next;
            flag   <= '{sign: res_next[WIDTH-1], zero: zacc & ~|r_s,
                        overflow: arith & (cmsb ^ cout), carryOut: arith & cout};
            cmp    <= '{ge: ~lt, lt: lt, ne: ~deq, eq: deq};
            state  <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// Directed + randomized bench for serial_alu against a plain-arithmetic reference model.
module tb_serial_alu;
  import defs::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0, b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  t_flag       flag;
  t_cmp        cmp;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_r = '0;
  logic [3:0]  prev_f = '0, prev_c = '0;

  always #5 clk = ~clk;

  serial_alu #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag(flag), .cmp(cmp)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flag word {sign,zero,overflow,carryOut}; compare word {ge,lt,ne,eq}.
  function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [3:0] f, output logic [3:0] c);
    logic [32:0] s;
    logic co, ov, lt;
    co = 1'b0; ov = 1'b0; r = '0;
    case (o)
      4'd1: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[31:0]; co = s[32];
        ov = (x[31] == y[31]) && (r[31] != x[31]);
      end
      4'd2: begin
        s = {1'b0, x} + {1'b0, ~y} + 33'd1;
        r = s[31:0]; co = s[32];
        ov = (x[31] != y[31]) && (r[31] != x[31]);
      end
      4'd3: r = x & y;
      4'd4: r = x | y;
      4'd5: r = x ^ y;
      default: r = '0;
    endcase
    lt = $signed(x) < $signed(y);
    f = {r[31], r == 32'd0, ov, co};
    c = {~lt, lt, x != y, x == y};
  endfunction

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] er;
    logic [3:0]  ef, ec;
    int n;
    model(o, x, y, er, ef, ec);
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      check("result_held_run", 64'(result), 64'(prev_r));
      check("in_ready_run", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1 n++;
    end
    check("latency", 64'(n), 64'd4);
    check("result", 64'(result), 64'(er));
    check("flag", 64'(flag), 64'(ef));
    check("cmp", 64'(cmp), 64'(ec));
    prev_r = er; prev_f = ef; prev_c = ec;
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("out_valid_drop", 64'(out_valid), 64'd0);
    check("in_ready_back", 64'(in_ready), 64'd1);
    check("result_held_idle", 64'(result), 64'(prev_r));
  endtask

  logic [31:0] edges [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h55AA_55AA};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flag", 64'(flag), 64'd0);
    check("rst_cmp", 64'(cmp), 64'd0);
    @(negedge clk) rst = 1'b0;

    issue(4'd1, 32'h7FFF_FFFF, 32'h1);          release_out();
    issue(4'd2, 32'd5, 32'd5);                  release_out();
    issue(4'd2, 32'd0, 32'd1);                  release_out();
    issue(4'd2, 32'h8000_0000, 32'd1);          release_out();
    issue(4'd3, 32'hF0F0_1234, 32'h0FF0_FF00);  release_out();
    issue(4'd4, 32'hF0F0_1234, 32'h0FF0_FF00);  release_out();
    issue(4'd5, 32'hF0F0_1234, 32'h0FF0_FF00);  release_out();
    issue(4'd0, 32'h1234_5678, 32'h1234_5678);  release_out();

    // Backpressure with an ignored second request.
    issue(4'd1, 32'h0000_FFFF, 32'h0000_0001);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 4'd5; a = $urandom; b = $urandom;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_result", 64'(result), 64'(prev_r));
      check("bp_flag", 64'(flag), 64'(prev_f));
      check("bp_cmp", 64'(cmp), 64'(prev_c));
    end
    @(negedge clk) in_valid = 1'b0;
    release_out();
    @(negedge clk);
    check("bp_no_queue", 64'(out_valid), 64'd0);
    issue(4'd2, 32'd100, 32'd7);                release_out();

    // Reset during RUN aborts the operation.
    @(negedge clk);
    op = 4'd1; a = 32'd1; b = 32'd2; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_result", 64'(result), 64'd0);
    check("abort_flag", 64'(flag), 64'd0);
    check("abort_cmp", 64'(cmp), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_valid", 64'(out_valid), 64'd0);
    end
    prev_r = '0; prev_f = '0; prev_c = '0;

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  o;
      logic [31:0] x, y;
      o = 4'($urandom_range(0, 7));
      x = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      y = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) y = x;
      issue(o, x, y);
      release_out();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_alu.md
# serial_alu

Multi-cycle, slice-serial execution unit that consumes the `aluop` encoding issued by the hardwired controller. It returns the result, a `t_flag` status word and a `t_cmp` compare word. Each operation processes `SLICE` bits per cycle, LSB first, so a narrow datapath covers a full `WIDTH`-bit word. The unit sits between the controller's issue stage and register writeback, with valid/ready handshakes on both sides.

## Interface

Parameters:

- `WIDTH`, 32: operand and result width.
- `SLICE`, 8: bits processed per cycle. Must divide `WIDTH`. `N = WIDTH/SLICE`.

Ports:

- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: reset. Asynchronous, active-high.
- `in_valid`, input, 1: controller presents an operation.
- `in_ready`, output, 1: unit can accept an operation.
- `op`, input, 4: `t_aluop` encoding.
- `a`, input, `WIDTH`: first operand.
- `b`, input, `WIDTH`: second operand.
- `out_valid`, output, 1: result, `flag` and `cmp` are valid.
- `out_ready`, input, 1: consumer accepts the result.
- `result`, output, `WIDTH`: operation result.
- `flag`, output, `t_flag`: sign, zero, overflow, carryOut.
- `cmp`, output, `t_cmp`: ge, lt, ne, eq for `a` versus `b`, signed.

## Operation

FSM states are IDLE, RUN and DONE.

- **IDLE**
  - `in_ready=1`.
  - When `in_valid` is high: latch `op`, `a`, `b`; clear the slice counter, carry registers and zero accumulators; go to RUN.
- **RUN**
  - `in_ready=0`.
  - Each cycle processes slice `k` (bits `[k*SLICE +: SLICE]`), shifts the result slice into the result register and registers the carries.
  - After slice `N-1`, go to DONE.
- **DONE**
  - `out_valid=1`. `result`, `flag` and `cmp` are held stable.
  - On `out_ready`, go to IDLE.

Arithmetic:

- ADD computes `a+b`. SUB computes `a+~b+1`, with the carry register seeded to 1.
- AND, OR and XOR are bitwise.
- A parallel compare subtractor computes `a-b` for every op, independent of `op`.

Flags:

- `sign` = `result[WIDTH-1]`.
- `zero` = `result==0`, accumulated per slice.
- `carryOut` = carry out of the MSB for ADD/SUB; for SUB, 1 means no borrow. It is 0 for logic ops.
- `overflow` = carry into the MSB XOR carry out of the MSB for ADD/SUB. It is 0 for logic ops.

Compare:

- `eq` = (a-b)==0.
- `ne` = !eq.
- `lt` = diff sign XOR diff overflow.
- `ge` = !lt.

Illegal `op` (any value outside the five codes): `result=0`, `zero=1`, all other flags 0. `cmp` is still computed, and latency is unchanged.

## Timing

- Reset values: state IDLE, `in_ready=1` (decoded from state), `out_valid=0`, `result=0`, `flag=0`, `cmp=0`.
- Accept edge E0 is the edge where `in_valid && in_ready`. RUN covers edges E1..EN. `out_valid` rises after edge EN, i.e. `N` cycles after E0 (4 cycles at the defaults).
- `out_valid` holds until the edge where `out_ready=1`. `in_ready` returns to 1 in the next cycle. Minimum issue interval is `N+2` cycles.
- `in_valid` while busy is ignored. There is no queueing.
- `out_ready` while not `out_valid` has no effect.
- `result`, `flag` and `cmp` change only on the RUN→DONE transition. They retain their previous values in IDLE and RUN.
- `rst` asserted mid-RUN or mid-DONE aborts the operation: no `out_valid` is produced, and all outputs return to their reset values immediately.

## Structure

- Package `defs` gains a named `typedef enum logic [3:0] t_aluop` with the existing encodings (ADD=1, SUB=2, AND=3, OR=4, XOR=5). The existing `aluop` is declared with it.
- `t_flag` and `t_cmp` are reused unchanged.
- The FSM state enum is local to `serial_alu`.
- Sub-module `alu_slice` is purely combinational. It takes a `SLICE`-bit op slice, both operand slices, a main carry-in and a compare carry-in. It returns the result slice, main carry-out, compare diff slice, compare carry-out, and carry-into-MSB for overflow.
- `serial_alu` holds the FSM, slice counter, operand shift registers and flag/compare accumulation.

## Test plan

- ADD `a=0x7FFFFFFF`, `b=1` -> `result=0x80000000`, sign=1, overflow=1, zero=0, carryOut=0; cmp ge=1, lt=0, ne=1, eq=0; `out_valid` rises exactly 4 cycles after accept.
- SUB `a=5`, `b=5` -> `result=0`, zero=1, carryOut=1, overflow=0; cmp eq=1, ge=1, lt=0.
- SUB `a=0`, `b=1` -> `result=0xFFFFFFFF`, sign=1, carryOut=0; cmp lt=1, ne=1. Then SUB `a=0x80000000`, `b=1` -> overflow=1, cmp lt=1.
- AND/OR/XOR with `a=0xF0F0_1234`, `b=0x0FF0_FF00` -> `0x00F0_1200` / `0xFFF0_FF34` / `0xFF00_ED34`; carryOut=0, overflow=0.
- Backpressure: hold `out_ready=0` for 6 cycles -> outputs stable and `in_ready=0` throughout; a new `in_valid` during that time is ignored. Release -> `in_ready=1` next cycle.
- `rst` pulse at E2 of a RUN -> `out_valid` never asserts, outputs zero, `in_ready=1`. Illegal `op=4'b0000` -> `result=0`, zero=1, cmp computed.
